mult_share_arbiter: RTL and testbench

Shares one pipelined multiplier (p_multiplier, fixed total latency) between NUM_REQ requesters.
Grants one request per cycle in round-robin order and drives the operands into the multiplier.
Tracks each in-flight operation with a tag shift register and returns the product to the originating requester.
Provides a drain handshake, so software or the control FSM can quiesce the multiplier before reconfiguration.

---
 rtl/mult_share_arbiter.sv | 127 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined multiplier between NUM_REQ requesters,
// with tag tracking for product return and a drain handshake for quiescing.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MULT_PIPE = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       mult_en,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  input  logic [2*WIDTH-1:0]         mult_res,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]         rsp_data,
  output logic                       busy,
  input  logic                       drain,
  output logic                       drain_done
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 grant_any;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;
  logic [MULT_PIPE-1:0] tag_v;
  logic [MULT_PIPE-1:0] tag_v_nxt;
  logic [PTR_W-1:0]     tag_id [MULT_PIPE];

  // Round-robin search: first from ptr upward, then wrap to indices below ptr.
  always_comb begin
    grant_any = 1'b0;
    gnt_idx   = '0;
    if (!reset && !drain && state == RUN) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!grant_any && i >= int'(ptr) && req[i]) begin
          grant_any = 1'b1;
          gnt_idx   = PTR_W'(i);
        end
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!grant_any && i < int'(ptr) && req[i]) begin
          grant_any = 1'b1;
          gnt_idx   = PTR_W'(i);
        end
      end
    end
    gnt = grant_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  // Operands of the granted requester, zero when nothing is granted.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign tag_v_nxt = (tag_v << 1) | MULT_PIPE'(grant_any);
  assign rsp_data  = mult_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      ptr        <= '0;
      mult_en    <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      tag_v      <= '0;
      busy       <= 1'b0;
      rsp_valid  <= '0;
      drain_done <= 1'b0;
      for (int i = 0; i < int'(MULT_PIPE); i++) tag_id[i] <= '0;
    end else begin
      mult_en   <= 1'b1;
      mult_a    <= sel_a;
      mult_b    <= sel_b;
      tag_v     <= tag_v_nxt;
      busy      <= |tag_v_nxt;
      tag_id[0] <= gnt_idx;
      for (int i = 1; i < int'(MULT_PIPE); i++) tag_id[i] <= tag_id[i-1];
      rsp_valid <= tag_v[MULT_PIPE-1] ? (NUM_REQ'(1) << tag_id[MULT_PIPE-1]) : '0;

      if (grant_any) begin
        ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end

      // Drain handshake; busy is the registered view of the tag pipe.
      drain_done <= 1'b0;
      case (state)
        RUN: begin
          if (drain) state <= DRAIN;
        end
        DRAIN: begin
          if (!drain) begin
            state <= RUN;
          end else if (!busy) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end
        end
        DONE: begin
          if (!drain) begin
            state <= RUN;
          end else begin
            drain_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a 5-stage behavioural multiplier model.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  gnt;
  logic        mult_en;
  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic [15:0] mult_res;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic        drain;
  logic        drain_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] mpipe [5];

  mult_share_arbiter #(.NUM_REQ(4), .WIDTH(8), .MULT_PIPE(5)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b),
    .mult_res(mult_res), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .drain(drain), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  // Product appears 5 cycles after the operands are presented.
  always @(posedge clk) begin
    mpipe[0] <= 16'(mult_a) * 16'(mult_b);
    for (int i = 1; i < 5; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_res = mpipe[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [7:0] a, input logic [7:0] b);
    req_a[lane*8 +: 8] = a;
    req_b[lane*8 +: 8] = b;
  endtask

  task automatic set_ops();
    set_lane(0, 8'd255, 8'd255);
    set_lane(1, 8'd3,   8'd4);
    set_lane(2, 8'd10,  8'd20);
    set_lane(3, 8'd100, 8'd7);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; drain = 1'b0; set_ops();
    step();
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if ({mult_en, mult_a, mult_b, rsp_valid, busy, drain_done} !== 23'd0) begin
      errors++; $display("FAIL reset_outs got en=%b a=%h b=%h rv=%b busy=%b dd=%b exp all 0",
                         mult_en, mult_a, mult_b, rsp_valid, busy, drain_done);
    end
    reset = 1'b0; req = 4'b0000;
    step();
    #1;
    checks++; if (mult_en !== 1'b1) begin errors++; $display("FAIL reset_mult_en got %b exp 1", mult_en); end
  endtask

  task automatic test_all_requesting();
    logic [3:0]  exp_g [5];
    logic [15:0] exp_d [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{16'd65025, 16'd12, 16'd200, 16'd700, 16'd65025};
    for (int k = 0; k <= 10; k++) begin
      step();
      req = (k < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 5) begin
        checks++; if (gnt !== exp_g[k]) begin errors++; $display("FAIL all_gnt[%0d] got %b exp %b", k, gnt, exp_g[k]); end
      end
      if (k >= 6) begin
        checks++; if (rsp_valid !== exp_g[k-6] || rsp_data !== exp_d[k-6]) begin
          errors++; $display("FAIL all_rsp[%0d] got %b/%0d exp %b/%0d", k, rsp_valid, rsp_data, exp_g[k-6], exp_d[k-6]);
        end
      end
    end
  endtask

  task automatic test_single();
    set_lane(2, 8'd12, 8'd13);
    for (int k = 0; k <= 6; k++) begin
      step();
      req = (k == 0) ? 4'b0100 : 4'b0000;
      #1;
      if (k == 0) begin
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", gnt); end
      end else if (k < 6) begin
        checks++; if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin
          errors++; $display("FAIL single_busy[%0d] got busy=%b rv=%b exp 1/0000", k, busy, rsp_valid);
        end
      end else begin
        checks++; if (rsp_valid !== 4'b0100 || rsp_data !== 16'd156 || busy !== 1'b0) begin
          errors++; $display("FAIL single_rsp got %b/%0d busy=%b exp 0100/156 busy=0", rsp_valid, rsp_data, busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [3];
    exp_d = '{16'd6, 16'd20, 16'd42};
    for (int k = 0; k <= 9; k++) begin
      step();
      req = (k < 3) ? 4'b0001 : 4'b0000;
      if (k < 3) set_lane(0, 8'(2 + 2*k), 8'(3 + 2*k));
      #1;
      if (k < 3) begin
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL b2b_gnt[%0d] got %b exp 0001", k, gnt); end
      end
      if (k >= 6 && k <= 8) begin
        checks++; if (rsp_valid !== 4'b0001 || rsp_data !== exp_d[k-6]) begin
          errors++; $display("FAIL b2b_rsp[%0d] got %b/%0d exp 0001/%0d", k, rsp_valid, rsp_data, exp_d[k-6]);
        end
      end
      if (k == 9) begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL b2b_tail got %b exp 0000", rsp_valid); end
      end
    end
  endtask

  task automatic test_drain();
    set_ops();
    for (int k = 0; k <= 17; k++) begin
      step();
      req   = (k < 2 || (k >= 3 && k <= 11)) ? 4'b1111 : 4'b0000;
      drain = (k >= 3 && k <= 9);
      #1;
      if (k == 0) begin
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drain_gnt0 got %b exp 0010", gnt); end
      end
      if (k == 1) begin
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL drain_gnt1 got %b exp 0100", gnt); end
      end
      if (k >= 3 && k <= 10) begin
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drain_mask[%0d] got %b exp 0000", k, gnt); end
      end
      if (k >= 3 && k <= 11) begin
        checks++; if (drain_done !== (k >= 8 && k <= 10)) begin
          errors++; $display("FAIL drain_done[%0d] got %b exp %b", k, drain_done, (k >= 8 && k <= 10));
        end
      end
      if (k == 6) begin
        checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 16'd12 || busy !== 1'b1) begin
          errors++; $display("FAIL drain_rsp1 got %b/%0d busy=%b exp 0010/12 busy=1", rsp_valid, rsp_data, busy);
        end
      end
      if (k == 7) begin
        checks++; if (rsp_valid !== 4'b0100 || rsp_data !== 16'd200 || busy !== 1'b0) begin
          errors++; $display("FAIL drain_rsp2 got %b/%0d busy=%b exp 0100/200 busy=0", rsp_valid, rsp_data, busy);
        end
      end
      if (k == 11) begin
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL drain_resume got %b exp 1000", gnt); end
      end
      if (k == 17) begin
        checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 16'd700) begin
          errors++; $display("FAIL drain_resume_rsp got %b/%0d exp 1000/700", rsp_valid, rsp_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_flight();
    for (int k = 0; k <= 12; k++) begin
      step();
      req   = (k < 3 || k == 4) ? 4'b1111 : 4'b0000;
      reset = (k == 4);
      #1;
      if (k < 3) begin
        checks++; if (gnt !== (4'b0001 << k)) begin errors++; $display("FAIL rst_mid_gnt[%0d] got %b exp %b", k, gnt, 4'b0001 << k); end
      end
      if (k == 4) begin
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_mid_gnt_mask got %b exp 0000", gnt); end
      end
      if (k == 5) begin
        checks++; if ({mult_en, mult_a, mult_b, busy, drain_done} !== 19'd0) begin
          errors++; $display("FAIL rst_mid_outs got en=%b a=%h b=%h busy=%b dd=%b exp all 0",
                             mult_en, mult_a, mult_b, busy, drain_done);
        end
      end
      if (k == 6) begin
        checks++; if (mult_en !== 1'b1) begin errors++; $display("FAIL rst_mid_mult_en got %b exp 1", mult_en); end
      end
      if (k >= 5) begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_mid_rsp[%0d] got %b exp 0000", k, rsp_valid); end
      end
    end
  endtask

  task automatic test_drain_same_cycle();
    for (int k = 0; k <= 10; k++) begin
      step();
      req   = (k <= 4) ? 4'b0010 : 4'b0000;
      drain = (k <= 2);
      #1;
      if (k <= 3) begin
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL same_mask[%0d] got %b exp 0000", k, gnt); end
      end
      if (k >= 1 && k <= 4) begin
        checks++; if (drain_done !== (k == 2 || k == 3)) begin
          errors++; $display("FAIL same_done[%0d] got %b exp %b", k, drain_done, (k == 2 || k == 3));
        end
      end
      if (k == 4) begin
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL same_resume got %b exp 0010", gnt); end
      end
      if (k == 10) begin
        checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 16'd12) begin
          errors++; $display("FAIL same_rsp got %b/%0d exp 0010/12", rsp_valid, rsp_data);
        end
      end
    end
  endtask

  initial begin
    req_a = '0;
    req_b = '0;
    test_reset();
    test_all_requesting();
    test_single();
    test_back_to_back();
    test_drain();
    test_reset_mid_flight();
    test_drain_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
